async_mem_bank: RTL and testbench

Single-port, word-addressed RAM with a synchronous write and a combinational (asynchronous) read. It serves as the work-RAM and video-RAM banks beside the `gameboy` core, sharing one address bus with chip-select-qualified read and write strobes. An optional post-reset clear sweep zero-fills the array and flags it busy until done.

---
 rtl/async_mem_pkg.sv | 20 ++
 rtl/async_mem_clr_seq.sv | 61 ++++++
 rtl/async_mem_bank.sv | 80 ++++++++
 tb/tb_async_mem_bank.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/async_mem_pkg.sv
// Shared types and helpers for the async_mem_bank RAM slice.
package async_mem_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_t;

    // Open-bus value returned when the bank is not driving data
    localparam logic [63:0] OPEN_BUS_FILL = '1;

    // Index width for a power-of-two depth; returns 0 for an illegal depth
    function automatic int unsigned clog2_chk(input int unsigned d);
        if (d < 2 || (d & (d - 1)) != 0) begin
            return 0;
        end
        return $clog2(d);
    endfunction

endpackage

// File: rtl/async_mem_clr_seq.sv
// Post-reset clear sweep: zero-fills every word once, holding busy until done.
module async_mem_clr_seq
    import async_mem_pkg::*;
#(
    parameter int unsigned depth = 8192,
    parameter int unsigned asz   = 8,
    localparam int unsigned PW   = clog2_chk(depth)
) (
    input  logic           wr_clk,
    input  logic           reset,
    output logic           busy,
    output logic           clr_we,
    output logic [PW-1:0]  clr_addr,
    output logic [asz-1:0] clr_data
);

    clr_state_t    state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          busy_q, busy_d;

    // State, pointer and busy registers
    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    // Sweep advances one word per edge and retires on the last index
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        case (state_q)
            CLEAR: begin
                ptr_d = ptr_q + PW'(1);
                if (ptr_q == PW'(depth - 1)) begin
                    state_d = READY;
                    busy_d  = 1'b0;
                end
            end
            READY: begin
                busy_d = 1'b0;
            end
            default: begin
                state_d = READY;
            end
        endcase
    end

    assign busy     = busy_q;
    assign clr_we   = (state_q == CLEAR);
    assign clr_addr = ptr_q;
    assign clr_data = '0;

endmodule

// File: rtl/async_mem_bank.sv
// Word-addressed RAM: synchronous write, combinational read, open-bus 0xFF.
// Optional post-reset zero-fill enabled by defining ASYNC_MEM_CLEAR_EN.
module async_mem_bank
    import async_mem_pkg::*;
#(
    parameter int unsigned asz   = 8,
    parameter int unsigned depth = 8192,
    parameter int unsigned aw    = 16
) (
    input  logic           wr_clk,
    input  logic           reset,
    input  logic [aw-1:0]  addr,
    input  logic [asz-1:0] wr_data,
    input  logic           wr_cs,
    input  logic           rd_cs,
    output logic [asz-1:0] rd_data,
    output logic           busy
);

    localparam int unsigned IW = clog2_chk(depth);

    if (clog2_chk(depth) == 0) begin : g_bad_depth
        $error("async_mem_bank: depth must be a power of two >= 2");
    end
    if (aw < IW) begin : g_bad_aw
        $error("async_mem_bank: aw narrower than index width");
    end

    logic [asz-1:0] mem [0:depth-1];
    logic [IW-1:0]  idx;
    logic           we;
    logic [IW-1:0]  waddr;
    logic [asz-1:0] wdata;

    // Upper address bits alias and are intentionally dropped
    assign idx = addr[IW-1:0];
    if (aw > IW) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^addr[aw-1:IW];
    end

`ifdef ASYNC_MEM_CLEAR_EN
    logic           clr_we;
    logic [IW-1:0]  clr_addr;
    logic [asz-1:0] clr_data;

    async_mem_clr_seq #(
        .depth (depth),
        .asz   (asz)
    ) u_clr_seq (
        .wr_clk   (wr_clk),
        .reset    (reset),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .clr_data (clr_data)
    );

    // Sweep owns the write port; user writes are dropped while busy
    assign we    = clr_we | (wr_cs & ~busy);
    assign waddr = clr_we ? clr_addr : idx;
    assign wdata = clr_we ? clr_data : wr_data;
`else
    logic unused_reset;
    assign unused_reset = reset;
    assign busy  = 1'b0;
    assign we    = wr_cs;
    assign waddr = idx;
    assign wdata = wr_data;
`endif

    always_ff @(posedge wr_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rd_data = (rd_cs && !busy) ? mem[idx] : asz'(OPEN_BUS_FILL);

endmodule

// File: tb/tb_async_mem_bank.sv
// Randomized self-checking bench for async_mem_bank against an array model.
// Follows ASYNC_MEM_CLEAR_EN the same way the RTL does.
module tb_async_mem_bank;

    localparam int unsigned DEPTH = 8192;

    logic        wr_clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic [7:0]  wr_data;
    logic        wr_cs;
    logic        rd_cs;
    logic [7:0]  rd_data;
    logic        busy;

    always #5 wr_clk = ~wr_clk;

    async_mem_bank #(
        .asz   (8),
        .depth (DEPTH),
        .aw    (16)
    ) dut (
        .wr_clk  (wr_clk),
        .reset   (reset),
        .addr    (addr),
        .wr_data (wr_data),
        .wr_cs   (wr_cs),
        .rd_cs   (rd_cs),
        .rd_data (rd_data),
        .busy    (busy)
    );

    // Reference contents; known marks words with a defined value
    logic [7:0] model [DEPTH];
    bit         known [DEPTH];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    function automatic int widx(input logic [15:0] a);
        return int'(a) % int'(DEPTH);
    endfunction

    task automatic model_fill_zero();
        for (int i = 0; i < int'(DEPTH); i++) begin
            model[i] = 8'h00;
            known[i] = 1'b1;
        end
    endtask

    // One-edge user write, reflected in the model
    task automatic mem_write(input logic [15:0] a, input logic [7:0] d);
        addr    = a;
        wr_data = d;
        wr_cs   = 1'b1;
        tick();
        wr_cs   = 1'b0;
        model[widx(a)] = d;
        known[widx(a)] = 1'b1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (busy !== 1'b0 && n < 20000) begin
            tick();
            n++;
        end
    endtask

    int          n;
    logic [15:0] ra;
    logic [7:0]  rd8;
    bit          rw, rr;

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            known[i] = 1'b0;
            model[i] = 8'h00;
        end
        wr_cs   = 1'b0;
        rd_cs   = 1'b1;
        addr    = 16'h0000;
        wr_data = 8'h00;

`ifdef ASYNC_MEM_CLEAR_EN
        // Reset and full sweep
        reset = 1'b1;
        tick();
        tick();
        check("reset_busy", 16'(busy), 16'h1);
        check("reset_rd_ff", 16'(rd_data), 16'h00ff);
        reset = 1'b0;
        tick();
        check("sweep_busy", 16'(busy), 16'h1);
        check("sweep_rd_ff", 16'(rd_data), 16'h00ff);
        wait_ready(n);
        check("sweep_len", 16'(n + 1), 16'(DEPTH));
        check("sweep_rd_zero", 16'(rd_data), 16'h0000);
        model_fill_zero();
`else
        // No reset; write on the very first edge
        reset   = 1'b0;
        addr    = 16'h1FFF;
        wr_data = 8'h3C;
        wr_cs   = 1'b1;
        #1;
        check("init_busy", 16'(busy), 16'h0);
        tick();
        wr_cs = 1'b0;
        model[DEPTH-1] = 8'h3C;
        known[DEPTH-1] = 1'b1;
        check("first_edge_wr", 16'(rd_data), 16'h003c);
        check("first_edge_busy", 16'(busy), 16'h0);
`endif

        // Aliasing
        mem_write(16'hC010, 8'hA5);
        rd_cs = 1'b1;
        addr  = 16'hC010;
        #1;
        check("rd_c010", 16'(rd_data), 16'h00a5);
        addr = 16'hE010;
        #1;
        check("rd_e010_alias", 16'(rd_data), 16'h00a5);
        addr = 16'hC011;
        #1;
        if (known[widx(addr)]) begin
            check("rd_c011", 16'(rd_data), 16'(model[widx(addr)]));
        end

        // Read disabled gives open bus
        addr  = 16'hC010;
        rd_cs = 1'b0;
        #1;
        check("rd_cs0_ff", 16'(rd_data), 16'h00ff);

        // Simultaneous read and write
        mem_write(16'h0003, 8'h11);
        addr    = 16'h0003;
        rd_cs   = 1'b1;
        wr_data = 8'h22;
        wr_cs   = 1'b1;
        #1;
        check("rw_old", 16'(rd_data), 16'h0011);
        tick();
        wr_cs = 1'b0;
        model[3] = 8'h22;
        check("rw_new", 16'(rd_data), 16'h0022);

        // Random traffic in a small window with random alias bits
        for (int i = 0; i < 400; i++) begin
            ra      = 16'(($urandom_range(0, 7) << 13) | $urandom_range(0, 31));
            wr_data = 8'($urandom);
            rw      = ($urandom_range(0, 1) == 1);
            rr      = ($urandom_range(0, 3) != 0);
            addr    = ra;
            wr_cs   = rw;
            rd_cs   = rr;
            #1;
            check("rand_busy", 16'(busy), 16'h0);
            if (!rr) begin
                check("rand_open_bus", 16'(rd_data), 16'h00ff);
            end else if (known[widx(ra)]) begin
                check("rand_rd_pre", 16'(rd_data), 16'(model[widx(ra)]));
            end
            rd8 = wr_data;
            tick();
            if (rw) begin
                model[widx(ra)] = rd8;
                known[widx(ra)] = 1'b1;
            end
            if (rr && known[widx(ra)]) begin
                check("rand_rd_post", 16'(rd_data), 16'(model[widx(ra)]));
            end
        end
        wr_cs = 1'b0;
        rd_cs = 1'b1;

`ifdef ASYNC_MEM_CLEAR_EN
        // Reset at sweep edge 100, held three cycles, then a dropped write
        addr  = 16'h0000;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 100; k++) tick();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("abort_busy", 16'(busy), 16'h1);
            check("abort_rd_ff", 16'(rd_data), 16'h00ff);
        end
        reset = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        addr    = 16'h0007;
        wr_data = 8'h5A;
        wr_cs   = 1'b1;
        tick();
        wr_cs = 1'b0;
        check("drop_busy", 16'(busy), 16'h1);
        wait_ready(n);
        check("restart_len", 16'(n + 11), 16'(DEPTH));
        model_fill_zero();
        check("dropped_wr", 16'(rd_data), 16'(model[7]));
        addr = 16'h0003;
        #1;
        check("cleared_0003", 16'(rd_data), 16'(model[3]));
        addr = 16'hC010;
        #1;
        check("cleared_c010", 16'(rd_data), 16'(model[16]));
`else
        addr = 16'h1FFF;
        #1;
        check("final_1fff", 16'(rd_data), 16'(model[DEPTH-1]));
        check("final_busy", 16'(busy), 16'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
